// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting input frequency per window
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             ovf,
    output logic             gate
);
    localparam int               GCW  = $clog2(GATE_CYCLES);
    localparam logic [GCW-1:0]   LAST = GCW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    logic             s1_q, s2_q, s3_q;
    logic             sig_rise;
    state_t           state_q;
    logic             arm_cnt_q;
    logic [GCW-1:0]   gate_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q;
    logic             freq_valid_q, ovf_q, gate_q;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sig_rise = s2_q & ~s3_q;

    // Saturating count including the current cycle's edge; also used for the final window cycle.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        if (sig_rise) begin
            if (edge_cnt_q == MAXC) begin
                sat_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            arm_cnt_q    <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            gate_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    arm_cnt_q  <= 1'b0;
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                    gate_q     <= 1'b0;
                    if (en) begin
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        arm_cnt_q <= 1'b0;
                    end else if (arm_cnt_q) begin
                        state_q    <= MEASURE;
                        gate_q     <= 1'b1;
                        arm_cnt_q  <= 1'b0;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        arm_cnt_q <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (gate_cnt_q == LAST) begin
                        freq_q       <= edge_cnt_d;
                        ovf_q        <= sat_d;
                        freq_valid_q <= 1'b1;
                        gate_cnt_q   <= '0;
                        edge_cnt_q   <= '0;
                        sat_q        <= 1'b0;
                        if (!en) begin
                            state_q <= IDLE;
                            gate_q  <= 1'b0;
                        end
                    end else if (!en) begin
                        // Partial window is dropped; published result stays untouched.
                        state_q    <= IDLE;
                        gate_q     <= 1'b0;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GCW'(1);
                        edge_cnt_q <= edge_cnt_d;
                        sat_q      <= sat_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gate_q  <= 1'b0;
                end
            endcase
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign ovf        = ovf_q;
    assign gate       = gate_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter (8-bit and 4-bit counter instances)
module tb_freq_meter;
    localparam int G = 100;

    logic       clk50m = 1'b0;
    logic       rst_n, en, sig_in;
    logic [7:0] freq8;
    logic       fv8, ovf8, gate8;
    logic [3:0] freq4;
    logic       fv4, ovf4, gate4;

    int n_tests = 0;
    int n_fail  = 0;

    bit gen_on     = 1'b0;
    bit gen_val    = 1'b0;
    bit man_sig    = 1'b0;
    int gen_period = 10;
    int gen_ph     = 0;

    assign sig_in = gen_on ? gen_val : man_sig;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
        .clk50m(clk50m), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq(freq8), .freq_valid(fv8), .ovf(ovf8), .gate(gate8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk50m(clk50m), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq(freq4), .freq_valid(fv4), .ovf(ovf4), .gate(gate4)
    );

    always #5 clk50m = ~clk50m;

    always @(posedge clk50m) begin
        #2;
        gen_ph  = gen_ph + 1;
        gen_val = ((gen_ph % gen_period) < (gen_period / 2));
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges are cycle numbers at which they must be counted; a window is a
    // span of G cycles and its result is the number of edges falling inside it.
    int  cyc        = 0;
    int  mode       = 0;
    int  arm_left   = 0;
    int  win_start  = 0;
    int  wcount     = 0;
    int  count_last = 0;
    bit  exp_fv     = 1'b0;
    bit  prev_sig   = 1'b0;
    bit  edge_now;
    int  eq[$];

    always @(negedge clk50m) begin
        if (!rst_n) begin
            mode       = 0;
            wcount     = 0;
            count_last = 0;
            exp_fv     = 1'b0;
            prev_sig   = 1'b0;
            eq.delete();
        end
        check("gate8", int'(gate8), int'(mode == 2));
        check("gate4", int'(gate4), int'(mode == 2));
        check("fv8", int'(fv8), int'(exp_fv));
        check("fv4", int'(fv4), int'(exp_fv));
        check("freq8", int'(freq8), (count_last > 255) ? 255 : count_last);
        check("ovf8", int'(ovf8), int'(count_last > 255));
        check("freq4", int'(freq4), (count_last > 15) ? 15 : count_last);
        check("ovf4", int'(ovf4), int'(count_last > 15));
        if (rst_n) begin
            cyc++;
            edge_now = 1'b0;
            while (eq.size() > 0 && eq[0] <= cyc) begin
                if (eq[0] == cyc) edge_now = 1'b1;
                void'(eq.pop_front());
            end
            if (sig_in && !prev_sig) eq.push_back(cyc + 2);
            prev_sig = sig_in;
            exp_fv   = 1'b0;
            case (mode)
                0: if (en) begin
                    mode     = 1;
                    arm_left = 2;
                end
                1: if (!en) begin
                    mode = 0;
                end else begin
                    arm_left--;
                    if (arm_left == 0) begin
                        mode      = 2;
                        win_start = cyc + 1;
                        wcount    = 0;
                    end
                end
                default: begin
                    wcount += int'(edge_now);
                    if (cyc == win_start + G - 1) begin
                        count_last = wcount;
                        exp_fv     = 1'b1;
                        wcount     = 0;
                        win_start  = cyc + 1;
                        if (!en) mode = 0;
                    end else if (!en) begin
                        mode = 0;
                    end
                end
            endcase
        end
    end

    task automatic wait_fv(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk50m);
            #1;
            n++;
        end while (!fv8 && n < 400);
        if (!fv8) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: freq_valid absent after %0d cycles, required within 400", name, n);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge clk50m);
        #1;
        check("rst_freq", int'(freq8), 0);
        check("rst_gate", int'(gate8), 0);
        check("rst_fv", int'(fv8), 0);
        check("rst_ovf", int'(ovf8), 0);
        rst_n      = 1'b1;
        gen_period = 10;
        gen_on     = 1'b1;
        repeat (5) @(posedge clk50m);
        #1;
        en = 1'b1;

        wait_fv("p10_first", n);
        check("p10_first_latency", n, 103);
        check("p10_first_freq8", int'(freq8), 10);
        check("p10_first_ovf8", int'(ovf8), 0);
        check("p10_first_freq4", int'(freq4), 10);
        wait_fv("p10_second", n);
        check("p10_period", n, 100);
        check("p10_second_freq8", int'(freq8), 10);
        check("p10_gate_between", int'(gate8), 1);

        gen_on  = 1'b0;
        man_sig = 1'b0;
        wait_fv("low_skip", n);
        wait_fv("low", n);
        check("low_period", n, 100);
        check("low_freq8", int'(freq8), 0);

        man_sig = 1'b1;
        wait_fv("high_skip", n);
        wait_fv("high", n);
        check("high_freq8", int'(freq8), 0);

        gen_period = 4;
        gen_on     = 1'b1;
        wait_fv("p4_skip", n);
        wait_fv("p4", n);
        check("p4_freq4", int'(freq4), 15);
        check("p4_ovf4", int'(ovf4), 1);
        check("p4_freq8", int'(freq8), 25);
        check("p4_ovf8", int'(ovf8), 0);

        gen_period = 20;
        wait_fv("p20_skip", n);
        wait_fv("p20", n);
        check("p20_freq4", int'(freq4), 5);
        check("p20_ovf4", int'(ovf4), 0);

        gen_period = 10;
        wait_fv("p10b_skip", n);
        wait_fv("p10b", n);
        check("p10b_freq8", int'(freq8), 10);
        repeat (50) @(posedge clk50m);
        #1;
        en = 1'b0;
        @(posedge clk50m);
        #1;
        check("abort_gate", int'(gate8), 0);
        repeat (20) @(posedge clk50m);
        #1;
        check("abort_freq_kept", int'(freq8), 10);
        en = 1'b1;
        wait_fv("rearm", n);
        check("rearm_latency", n, 103);
        check("rearm_freq8", int'(freq8), 10);

        gen_on  = 1'b0;
        man_sig = 1'b0;
        wait_fv("edge_skip", n);
        repeat (97) @(posedge clk50m);
        #1;
        man_sig = 1'b1;
        wait_fv("edge_last", n);
        check("edge_last_latency", n, 3);
        check("edge_last_freq8", int'(freq8), 1);
        man_sig = 1'b0;
        repeat (98) @(posedge clk50m);
        #1;
        man_sig = 1'b1;
        wait_fv("edge_after", n);
        check("edge_after_freq8", int'(freq8), 0);
        wait_fv("edge_first", n);
        check("edge_first_freq8", int'(freq8), 1);

        repeat (30) @(posedge clk50m);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_freq", int'(freq8), 0);
        check("midrst_gate", int'(gate8), 0);
        check("midrst_fv", int'(fv8), 0);
        check("midrst_ovf", int'(ovf8), 0);
        repeat (3) @(posedge clk50m);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk50m);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
